// File: rtl/lp_esc_pkg.sv
// Shared types and constants for the C-PHY low-power escape receiver.
// Line states are written {A, B, C}.
package lp_esc_pkg;

    typedef enum logic [3:0] {
        ST_STOP   = 4'd0,
        ST_REQ    = 4'd1,
        ST_BRIDGE = 4'd2,
        ST_ESC_RQ = 4'd3,
        ST_ESC_GO = 4'd4,
        ST_CMD    = 4'd5,
        ST_LPDT   = 4'd6,
        ST_ULPS   = 4'd7,
        ST_TRIG   = 4'd8,
        ST_EXIT   = 4'd9
    } escState_t;

    localparam logic [7:0] CMD_LPDT  = 8'hE1;
    localparam logic [7:0] CMD_ULPS  = 8'h1E;
    localparam logic [7:0] CMD_TRIG0 = 8'h62;
    localparam logic [7:0] CMD_TRIG1 = 8'h5D;
    localparam logic [7:0] CMD_TRIG2 = 8'h21;
    localparam logic [7:0] CMD_TRIG3 = 8'hA0;

    localparam logic [2:0] LP_111 = 3'b111;
    localparam logic [2:0] LP_100 = 3'b100;
    localparam logic [2:0] LP_000 = 3'b000;
    localparam logic [2:0] LP_001 = 3'b001;

    function automatic logic [3:0] trigOneHot(input logic [7:0] cmd);
        case (cmd)
            CMD_TRIG0: trigOneHot = 4'b0001;
            CMD_TRIG1: trigOneHot = 4'b0010;
            CMD_TRIG2: trigOneHot = 4'b0100;
            CMD_TRIG3: trigOneHot = 4'b1000;
            default:   trigOneHot = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lp_clk_recovery.sv
// Line synchronizer and escape clock recovery: one strobe per rising edge of
// RxClkEsc, with the bit value taken from the synchronized A line.
module lp_clk_recovery
    import lp_esc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    output logic [2:0] lineState,
    output logic       bitStrobe,
    output logic       bitValue
);

    logic [2:0] lineSync_r [SYNC_STAGES];
    logic       rxClkPrev_r;
    logic       RxClkEsc;

    assign lineState = lineSync_r[SYNC_STAGES-1];
    // Marks toggle A^C with B low; LP-000 spaces and any B-high state give no clock.
    assign RxClkEsc  = (lineState[1] == 1'b0) ? (lineState[2] ^ lineState[0]) : 1'b0;
    assign bitStrobe = RxClkEsc & ~rxClkPrev_r;
    assign bitValue  = lineState[2];

    // Synchronizer chain (idles at LP-111) and previous recovered clock level.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                lineSync_r[i] <= LP_111;
            end
            rxClkPrev_r <= 1'b0;
        end else begin
            lineSync_r[0] <= {A, B, C};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                lineSync_r[i] <= lineSync_r[i-1];
            end
            rxClkPrev_r <= RxClkEsc;
        end
    end

endmodule

// File: rtl/lp_test.sv
// C-PHY slave low-power escape receiver: escape entry detection, command
// decode, LPDT bit streaming, ULPS/trigger flags and error reporting.
module lp_test
    import lp_esc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       EscDecoderEn,
    input  logic       RequestDetection,
    output logic       RxLpdtEsc,
    output logic       RxUlpsEsc,
    output logic [3:0] RxTriggerEsc,
    output logic       EscBit,
    output logic       ErrControl,
    output logic       ErrSyncEsc,
    output logic       ErrEsc,
    output logic       LpFsmStop
);

    escState_t  state_r, stateNext_s, prior_r;
    logic [2:0] lineState_s;
    logic       bitStrobe_s, bitValue_s;
    logic [7:0] cmdShift_r;
    logic [3:0] cmdCnt_r;
    logic       cmdDone_r;
    logic [2:0] bitCnt_r;
    logic       exitBit_r;
    logic       ctrlErr_s, decodeNow_s, cmdTake_s, lpdtTake_s, enterStop_s, syncErr_s;
    logic [3:0] trig_s;

    lp_clk_recovery #(.SYNC_STAGES(SYNC_STAGES)) uClkRec (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .B         (B),
        .C         (C),
        .lineState (lineState_s),
        .bitStrobe (bitStrobe_s),
        .bitValue  (bitValue_s)
    );

    assign trig_s      = trigOneHot(cmdShift_r);
    assign cmdTake_s   = bitStrobe_s && EscDecoderEn && (state_r == ST_CMD) &&
                         !cmdDone_r && (cmdCnt_r < 4'd8);
    assign lpdtTake_s  = bitStrobe_s && EscDecoderEn && (state_r == ST_LPDT);
    assign enterStop_s = (state_r != ST_STOP) && (stateNext_s == ST_STOP);
    // The exit LP-100 is also a mark-1 edge; that tentative bit is discounted here.
    assign syncErr_s   = enterStop_s && (state_r == ST_EXIT) && (prior_r == ST_LPDT) &&
                         ((bitCnt_r - {2'b00, exitBit_r}) != 3'd0);

    // Next-state logic: entry sequence checks, command decode and exit handling.
    always_comb begin
        stateNext_s = state_r;
        ctrlErr_s   = 1'b0;
        decodeNow_s = 1'b0;
        case (state_r)
            ST_STOP: begin
                if (RequestDetection && (lineState_s == LP_100)) stateNext_s = ST_REQ;
                else                                             stateNext_s = ST_STOP;
            end
            ST_REQ: begin
                if (lineState_s == LP_000)      stateNext_s = ST_BRIDGE;
                else if (lineState_s == LP_100) stateNext_s = ST_REQ;
                else begin
                    stateNext_s = ST_STOP;
                    ctrlErr_s   = 1'b1;
                end
            end
            ST_BRIDGE: begin
                if (lineState_s == LP_001)      stateNext_s = ST_ESC_RQ;
                else if (lineState_s == LP_000) stateNext_s = ST_BRIDGE;
                else begin
                    stateNext_s = ST_STOP;
                    ctrlErr_s   = 1'b1;
                end
            end
            ST_ESC_RQ: begin
                if (lineState_s == LP_000)      stateNext_s = ST_ESC_GO;
                else if (lineState_s == LP_001) stateNext_s = ST_ESC_RQ;
                else begin
                    stateNext_s = ST_STOP;
                    ctrlErr_s   = 1'b1;
                end
            end
            ST_ESC_GO: stateNext_s = ST_CMD;
            ST_CMD: begin
                if (lineState_s == LP_100) begin
                    stateNext_s = ST_EXIT;
                end else if ((cmdCnt_r == 4'd8) && !cmdDone_r) begin
                    decodeNow_s = 1'b1;
                    if (cmdShift_r == CMD_LPDT)      stateNext_s = ST_LPDT;
                    else if (cmdShift_r == CMD_ULPS) stateNext_s = ST_ULPS;
                    else if (trig_s != 4'b0000)      stateNext_s = ST_TRIG;
                    else                             stateNext_s = ST_CMD;
                end else begin
                    stateNext_s = ST_CMD;
                end
            end
            ST_LPDT, ST_ULPS, ST_TRIG: begin
                if (lineState_s == LP_100) stateNext_s = ST_EXIT;
                else                       stateNext_s = state_r;
            end
            ST_EXIT: begin
                if (lineState_s == LP_111)      stateNext_s = ST_STOP;
                else if (lineState_s == LP_100) stateNext_s = ST_EXIT;
                else                            stateNext_s = prior_r;
            end
            default: stateNext_s = ST_STOP;
        endcase
    end

    // State register, remembered pre-exit state and registered stop indication.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= ST_STOP;
            prior_r   <= ST_STOP;
            LpFsmStop <= 1'b1;
        end else begin
            state_r   <= stateNext_s;
            LpFsmStop <= (stateNext_s == ST_STOP);
            if ((stateNext_s == ST_EXIT) && (state_r != ST_EXIT)) begin
                prior_r <= state_r;
            end
        end
    end

    // Command shift register, bit counters and recovered data bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cmdShift_r <= 8'h00;
            cmdCnt_r   <= 4'd0;
            cmdDone_r  <= 1'b0;
            bitCnt_r   <= 3'd0;
            exitBit_r  <= 1'b0;
            EscBit     <= 1'b0;
        end else begin
            if (state_r == ST_ESC_GO) begin
                cmdShift_r <= 8'h00;
                cmdCnt_r   <= 4'd0;
                cmdDone_r  <= 1'b0;
                bitCnt_r   <= 3'd0;
            end else begin
                if (cmdTake_s) begin
                    cmdShift_r <= {cmdShift_r[6:0], bitValue_s};
                    cmdCnt_r   <= cmdCnt_r + 4'd1;
                end
                if (decodeNow_s) cmdDone_r <= 1'b1;
                if (lpdtTake_s)  bitCnt_r  <= bitCnt_r + 3'd1;
            end
            if ((state_r == ST_LPDT) && (stateNext_s == ST_EXIT)) exitBit_r <= lpdtTake_s;
            if (cmdTake_s || lpdtTake_s) EscBit <= bitValue_s;
        end
    end

    // Mode flags (cleared on return to STOP) and sticky error flags (cleared on REQ).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RxLpdtEsc    <= 1'b0;
            RxUlpsEsc    <= 1'b0;
            RxTriggerEsc <= 4'b0000;
            ErrControl   <= 1'b0;
            ErrSyncEsc   <= 1'b0;
            ErrEsc       <= 1'b0;
        end else begin
            if ((state_r == ST_STOP) && (stateNext_s == ST_REQ)) begin
                ErrControl <= 1'b0;
                ErrSyncEsc <= 1'b0;
                ErrEsc     <= 1'b0;
            end else begin
                if (ctrlErr_s) ErrControl <= 1'b1;
                if (syncErr_s) ErrSyncEsc <= 1'b1;
                if (decodeNow_s && (stateNext_s == ST_CMD)) ErrEsc <= 1'b1;
            end
            if (enterStop_s) begin
                RxLpdtEsc    <= 1'b0;
                RxUlpsEsc    <= 1'b0;
                RxTriggerEsc <= 4'b0000;
            end else if (decodeNow_s) begin
                RxLpdtEsc    <= (cmdShift_r == CMD_LPDT);
                RxUlpsEsc    <= (cmdShift_r == CMD_ULPS);
                RxTriggerEsc <= trig_s;
            end
        end
    end

endmodule

// File: tb/tb_lp_test.sv
// Self-checking bench for lp_test: directed escape sequences plus randomized
// commands and LPDT payloads checked against a behavioural reference model.
module tb_lp_test;

    localparam int HOLD = 6;

    logic       CLK = 1'b0;
    logic       RST, A, B, C, EscDecoderEn, RequestDetection;
    logic       RxLpdtEsc, RxUlpsEsc, EscBit, ErrControl, ErrSyncEsc, ErrEsc, LpFsmStop;
    logic [3:0] RxTriggerEsc;

    int checks = 0;
    int errors = 0;

    logic [7:0] knownCmds [6] = '{8'hE1, 8'h1E, 8'h62, 8'h5D, 8'h21, 8'hA0};
    logic [7:0] trigCodes [4] = '{8'h62, 8'h5D, 8'h21, 8'hA0};

    always #5 CLK = ~CLK;

    lp_test #(.SYNC_STAGES(2)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .A                (A),
        .B                (B),
        .C                (C),
        .EscDecoderEn     (EscDecoderEn),
        .RequestDetection (RequestDetection),
        .RxLpdtEsc        (RxLpdtEsc),
        .RxUlpsEsc        (RxUlpsEsc),
        .RxTriggerEsc     (RxTriggerEsc),
        .EscBit           (EscBit),
        .ErrControl       (ErrControl),
        .ErrSyncEsc       (ErrSyncEsc),
        .ErrEsc           (ErrEsc),
        .LpFsmStop        (LpFsmStop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: what an escape command means at the protocol level.
    function automatic logic [3:0] refTrig(input logic [7:0] cmd);
        logic [3:0] r = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (cmd == trigCodes[i]) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic refErrEsc(input logic [7:0] cmd);
        return !((cmd == 8'hE1) || (cmd == 8'h1E) || (refTrig(cmd) != 4'b0000));
    endfunction

    task automatic setLine(input logic [2:0] s);
        {A, B, C} = s;
        repeat (HOLD) @(posedge CLK);
        #1;
    endtask

    task automatic sendBit(input logic b);
        setLine(3'b000);
        setLine(b ? 3'b100 : 3'b001);
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) sendBit(v[i]);
    endtask

    task automatic entry();
        setLine(3'b100);
        setLine(3'b000);
        setLine(3'b001);
        setLine(3'b000);
    endtask

    task automatic exitSeq();
        setLine(3'b000);
        setLine(3'b100);
        setLine(3'b111);
    endtask

    task automatic runCmd(input logic [7:0] cmd);
        entry();
        sendByte(cmd);
        setLine(3'b000);
        check("cmd_lpdt", {31'd0, RxLpdtEsc}, {31'd0, cmd == 8'hE1});
        check("cmd_ulps", {31'd0, RxUlpsEsc}, {31'd0, cmd == 8'h1E});
        check("cmd_trig", {28'd0, RxTriggerEsc}, {28'd0, refTrig(cmd)});
        check("cmd_erresc", {31'd0, ErrEsc}, {31'd0, refErrEsc(cmd)});
    endtask

    task automatic exitAndCheck();
        exitSeq();
        check("exit_stop", {31'd0, LpFsmStop}, 32'd1);
        check("exit_modes_clear", {26'd0, RxLpdtEsc, RxUlpsEsc, RxTriggerEsc}, 32'd0);
    endtask

    task automatic lpdtSession(input int n, input bit useDisable);
        logic b;
        runCmd(8'hE1);
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom_range(0, 1));
            sendBit(b);
            check("lpdt_escbit", {31'd0, EscBit}, {31'd0, b});
            if (useDisable && (i == 0)) begin
                EscDecoderEn = 1'b0;
                sendBit(~b);
                check("disabled_hold", {31'd0, EscBit}, {31'd0, b});
                check("disabled_mode", {31'd0, RxLpdtEsc}, 32'd1);
                EscDecoderEn = 1'b1;
            end
        end
        exitAndCheck();
        check("lpdt_errsync", {31'd0, ErrSyncEsc}, {31'd0, (n % 8) != 0});
    endtask

    initial begin
        logic [7:0] cmd;
        RST = 1'b1;
        {A, B, C} = 3'b111;
        EscDecoderEn = 1'b1;
        RequestDetection = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_stop", {31'd0, LpFsmStop}, 32'd1);
        check("rst_outs", {22'd0, RxLpdtEsc, RxUlpsEsc, RxTriggerEsc, EscBit,
                           ErrControl, ErrSyncEsc, ErrEsc}, 32'd0);
        RST = 1'b0;
        setLine(3'b111);

        // Detector disarmed: LP-100 then LP-111 must be ignored.
        setLine(3'b100);
        check("noreq_stop", {31'd0, LpFsmStop}, 32'd1);
        setLine(3'b111);
        check("noreq_noerr", {31'd0, ErrControl}, 32'd0);
        RequestDetection = 1'b1;

        // LPDT with 8 random bits, then spaces carry no clock.
        runCmd(8'hE1);
        check("lpdt_stop_low", {31'd0, LpFsmStop}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            logic b;
            b = 1'($urandom_range(0, 1));
            sendBit(b);
            check("lpdt8_escbit", {31'd0, EscBit}, {31'd0, b});
        end
        for (int i = 0; i < 5; i++) begin
            setLine(3'b000);
            check("space_noclk", {31'd0, dut.uClkRec.RxClkEsc}, 32'd0);
        end
        exitAndCheck();
        check("lpdt8_errsync", {31'd0, ErrSyncEsc}, 32'd0);

        // ULPS and trigger.
        runCmd(8'h1E);
        exitAndCheck();
        runCmd(8'h62);
        exitAndCheck();

        // Seven LPDT bits leave a partial byte.
        lpdtSession(7, 1'b0);

        // Unknown command, sticky error, cleared on the next request.
        runCmd(8'h63);
        exitAndCheck();
        check("erresc_sticky", {31'd0, ErrEsc}, 32'd1);
        setLine(3'b100);
        check("erresc_cleared", {31'd0, ErrEsc}, 32'd0);
        setLine(3'b111);
        check("errctrl_set", {31'd0, ErrControl}, 32'd1);
        check("errctrl_stop", {31'd0, LpFsmStop}, 32'd1);

        // Randomized commands and LPDT payload lengths.
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 0) cmd = knownCmds[$urandom_range(0, 5)];
            else                           cmd = 8'($urandom_range(0, 255));
            runCmd(cmd);
            exitAndCheck();
        end
        for (int k = 0; k < 3; k++) begin
            lpdtSession($urandom_range(1, 17), k == 0);
        end

        // Asynchronous reset mid-LPDT.
        runCmd(8'hE1);
        sendBit(1'b1);
        sendBit(1'b0);
        RST = 1'b1;
        #2;
        check("midrst_stop", {31'd0, LpFsmStop}, 32'd1);
        check("midrst_outs", {22'd0, RxLpdtEsc, RxUlpsEsc, RxTriggerEsc, EscBit,
                              ErrControl, ErrSyncEsc, ErrEsc}, 32'd0);
        {A, B, C} = 3'b111;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        setLine(3'b111);
        runCmd(8'h1E);
        exitAndCheck();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
